// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared state, entry type and default fetch addresses for the fetch stage
package if_fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, HALT} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;
  localparam logic [31:0] DEF_RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] DEF_EXC_PC = 32'hbfc0_0380;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: circular buffer of fetch entries with multi-entry push/pop and sync flush
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PUSH_W = 2,
  parameter int POP_W = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int PNW = $clog2(PUSH_W + 1),
  localparam int QNW = $clog2(POP_W + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [PNW-1:0]            push_n,
  input  fetch_entry_t [PUSH_W-1:0] push_data,
  input  logic [QNW-1:0]            pop_n,
  output fetch_entry_t [POP_W-1:0]  head,
  output logic [CW-1:0]             count,
  output logic [CW-1:0]             free
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < PUSH_W; i++)
      if (!reset && !flush && push_n > PNW'(i)) mem[wr_ptr + AW'(i)] <= push_data[i];
  for (genvar g = 0; g < POP_W; g++) begin : g_head
    assign head[g] = mem[rd_ptr + AW'(g)];
  end
  assign free = CW'(DEPTH) - count;
endmodule

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction fetch stage issuing block requests into a decoupling queue feeding ID
module if_fetch_buf
  import if_fetch_pkg::*;
#(
  parameter int          ISSUE_W = 2,
  parameter int          DEPTH = 8,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC = DEF_EXC_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [32*ISSUE_W-1:0]  imem_rdata,
  input  logic                   exc_valid,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [ISSUE_W-1:0]     id_valid,
  output logic [32*ISSUE_W-1:0]  id_inst,
  output logic [32*ISSUE_W-1:0]  id_pc,
  output logic [ISSUE_W-1:0]     id_adel,
  input  logic                   id_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(ISSUE_W + 1);
  fetch_state_e state;
  logic [31:0] fetch_pc, req_addr;
  logic drop, flush, misal, room, idle_req, adel_push, rsp_push;
  logic [CW-1:0] count, free;
  logic [NW-1:0] push_n, pop_n;
  fetch_entry_t [ISSUE_W-1:0] push_data, head;
  assign flush = exc_valid || redirect_valid;
  assign misal = fetch_pc[1:0] != 2'b00;
  assign room = free >= CW'(ISSUE_W);
  // a request reserves a whole block of queue space so its response can always be pushed
  assign idle_req = state == IDLE && !misal && room && !flush && !reset;
  assign adel_push = state == IDLE && misal && free != '0 && !flush;
  assign rsp_push = state == WAIT_RSP && imem_rvalid && !drop && !flush;
  assign imem_req = idle_req || (state == WAIT_GNT && !reset);
  assign imem_addr = state == IDLE ? fetch_pc : req_addr;
  assign push_n = rsp_push ? NW'(ISSUE_W) : NW'(adel_push);
  assign pop_n = id_ready ? (count < CW'(ISSUE_W) ? NW'(count) : NW'(ISSUE_W)) : '0;
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
    assign push_data[g] = fetch_entry_t'{
      pc: adel_push ? fetch_pc : req_addr + 32'(4 * g),
      inst: adel_push ? 32'd0 : imem_rdata[32*g +: 32],
      adel: adel_push
    };
    assign id_valid[g] = count > CW'(g);
    assign id_pc[32*g +: 32] = id_valid[g] ? head[g].pc : 32'd0;
    assign id_inst[32*g +: 32] = id_valid[g] ? head[g].inst : 32'd0;
    assign id_adel[g] = id_valid[g] && head[g].adel;
  end
  if_fetch_fifo #(.DEPTH(DEPTH), .PUSH_W(ISSUE_W), .POP_W(ISSUE_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push_n(push_n),
    .push_data(push_data),
    .pop_n(pop_n),
    .head(head),
    .count(count),
    .free(free)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      drop <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (adel_push) state <= HALT;
          else if (idle_req) begin
            req_addr <= fetch_pc;
            state <= imem_gnt ? WAIT_RSP : WAIT_GNT;
          end
        WAIT_GNT: if (imem_gnt) state <= WAIT_RSP;
        WAIT_RSP: if (imem_rvalid) state <= IDLE;
        HALT: if (flush) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rsp_push) fetch_pc <= fetch_pc + 32'(4 * ISSUE_W);
      if (flush) fetch_pc <= exc_valid ? EXC_PC : redirect_pc;
      // an outstanding request still completes after a flush; only its data is discarded
      if (state == WAIT_RSP && imem_rvalid) drop <= 1'b0;
      else if (flush && (state == WAIT_GNT || state == WAIT_RSP)) drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: table vectors, corner sequences and a randomized stream scoreboard for if_fetch_buf
module tb_if_fetch_buf;
  import if_fetch_pkg::*;
  localparam int W = 2;
  localparam logic [31:0] B = 32'hbfc0_0000;
  localparam logic [31:0] E = 32'hbfc0_0380;
  localparam logic [31:0] R1 = 32'h8000_0100;
  logic clk = 1'b0, reset = 1'b1;
  logic imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, redirect_pc = '0;
  logic [32*W-1:0] imem_rdata = '0, id_inst, id_pc;
  logic exc_valid = 1'b0, redirect_valid = 1'b0, id_ready = 1'b0;
  logic [W-1:0] id_valid, id_adel;
  if_fetch_buf #(.ISSUE_W(W), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .exc_valid(exc_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel), .id_ready(id_ready)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {
    logic rdy, ex, rd; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic [1:0] vld; logic [31:0] pc0;
  } vec_t;
  pend_t pend[$];
  vec_t tbl [23];
  int cyc = 0, n_tests = 0, n_fail = 0, gnt_pct = 100, lat_lo = 1, lat_hi = 1, delivered = 0, r;
  logic rst_next = 1'b1, sb_on = 1'b0, prev_flush = 1'b0, prev_hold = 1'b0;
  logic [31:0] prev_addr = '0, exp_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stream model: ID must see consecutive PCs from the last flush target, with inst = ~pc
  task automatic score();
    if (prev_flush) chk("flush_clears_id", 32'(id_valid), 0);
    if (prev_hold) begin
      chk("hold_req", 32'(imem_req), 1);
      chk("hold_addr", imem_addr, prev_addr);
    end
    chk("slot_order", 32'(id_valid[1] & ~id_valid[0]), 0);
    if (id_ready && !exc_valid && !redirect_valid)
      for (int k = 0; k < W; k++)
        if (id_valid[k]) begin
          chk("stream_pc", id_pc[32*k +: 32], exp_pc);
          chk("stream_inst", id_inst[32*k +: 32], ~exp_pc);
          chk("stream_adel", 32'(id_adel[k]), 0);
          exp_pc += 4;
          delivered++;
        end
    if (exc_valid || redirect_valid) exp_pc = exc_valid ? E : redirect_pc;
    prev_flush = exc_valid || redirect_valid;
    prev_hold = imem_req && !imem_gnt;
    prev_addr = imem_addr;
  endtask

  task automatic tick(input int rdy, input int ex, input int rd, input logic [31:0] rp);
    @(negedge clk);
    reset = rst_next;
    id_ready = 1'(rdy);
    exc_valid = 1'(ex);
    redirect_valid = 1'(rd);
    redirect_pc = rp;
    imem_gnt = $urandom_range(99) < gnt_pct;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if (reset) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      for (int k = 0; k < W; k++) imem_rdata[32*k +: 32] = ~(pend[0].addr + 32'(4 * k));
      void'(pend.pop_front());
    end
    #1;
    if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
    if (sb_on) score();
    cyc++;
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, B);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_pc", id_pc[31:0] | id_pc[63:32], 0);
    chk("rst_inst", id_inst[31:0] | id_inst[63:32], 0);
    chk("rst_adel", 32'(id_adel), 0);
    rst_next = 1'b0;
  endtask

  function automatic vec_t v(logic rdy, logic ex, logic rd, logic [31:0] rpc, logic req,
                             logic [31:0] addr, logic [1:0] vld, logic [31:0] pc0);
    return '{rdy, ex, rd, rpc, req, addr, vld, pc0};
  endfunction

  initial begin
    tbl = '{
      v(1'b0, 1'b0, 1'b0, 0, 1'b1, B,      2'b00, 0),
      v(1'b0, 1'b0, 1'b0, 0, 1'b0, 0,      2'b00, 0),
      v(1'b0, 1'b0, 1'b0, 0, 1'b1, B + 8,  2'b11, B),
      v(1'b0, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B),
      v(1'b0, 1'b0, 1'b0, 0, 1'b1, B + 16, 2'b11, B),
      v(1'b0, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B),
      v(1'b0, 1'b0, 1'b0, 0, 1'b1, B + 24, 2'b11, B),
      v(1'b0, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B),
      v(1'b0, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B),
      v(1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, B + 32, 2'b11, B + 8),
      v(1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B + 16),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, B + 40, 2'b11, B + 24),
      v(1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      2'b11, B + 32),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, B + 48, 2'b11, B + 40),
      v(1'b1, 1'b0, 1'b1, R1, 1'b0, 0,     2'b00, 0),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, R1,     2'b00, 0),
      v(1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      2'b00, 0),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, R1 + 8, 2'b11, R1),
      v(1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 0, 2'b00, 0),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, E,      2'b00, 0),
      v(1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      2'b00, 0),
      v(1'b1, 1'b0, 1'b0, 0, 1'b1, E + 8,  2'b11, E)
    };
    do_reset();
    foreach (tbl[i]) begin
      tick(tbl[i].rdy, tbl[i].ex, tbl[i].rd, tbl[i].rpc);
      chk("tbl_req", 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", 32'(id_valid), 32'(tbl[i].vld));
      if (tbl[i].vld[0]) begin
        chk("tbl_pc0", id_pc[31:0], tbl[i].pc0);
        chk("tbl_inst0", id_inst[31:0], ~tbl[i].pc0);
      end
      if (tbl[i].vld[1]) chk("tbl_pc1", id_pc[63:32], tbl[i].pc0 + 4);
    end
    // redirect while the response is still in flight
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    tick(1, 0, 0, 0);
    chk("late_req", 32'(imem_req), 1);
    chk("late_addr", imem_addr, B);
    tick(1, 0, 1, R1);
    chk("late_wait_req", 32'(imem_req), 0);
    tick(1, 0, 0, 0);
    chk("late_drop_req", 32'(imem_req), 0);
    tick(1, 0, 0, 0);
    chk("late_rsp_valid", 32'(id_valid), 0);
    tick(1, 0, 0, 0);
    chk("late_new_req", 32'(imem_req), 1);
    chk("late_new_addr", imem_addr, R1);
    chk("late_no_stale", 32'(id_valid), 0);
    for (int i = 0; i < 20 && !id_valid[0]; i++) tick(0, 0, 0, 0);
    chk("late_valid", 32'(id_valid[0]), 1);
    chk("late_pc0", id_pc[31:0], R1);
    lat_lo = 1;
    lat_hi = 1;
    // misaligned redirect halts after one adel slot
    do_reset();
    tick(1, 0, 1, 32'h8000_0102);
    chk("mis_flush_req", 32'(imem_req), 0);
    tick(1, 0, 0, 0);
    chk("mis_req", 32'(imem_req), 0);
    chk("mis_valid_early", 32'(id_valid), 0);
    tick(1, 0, 0, 0);
    chk("mis_valid", 32'(id_valid), 1);
    chk("mis_pc", id_pc[31:0], 32'h8000_0102);
    chk("mis_inst", id_inst[31:0], 0);
    chk("mis_adel", 32'(id_adel), 1);
    chk("mis_halt_req0", 32'(imem_req), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0);
      chk("mis_halt_req", 32'(imem_req), 0);
    end
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    chk("mis_exc_req", 32'(imem_req), 1);
    chk("mis_exc_addr", imem_addr, E);
    // reset while waiting for a grant
    do_reset();
    gnt_pct = 0;
    tick(0, 0, 1, R1);
    tick(0, 0, 0, 0);
    chk("gnt_req", 32'(imem_req), 1);
    chk("gnt_addr", imem_addr, R1);
    tick(0, 0, 0, 0);
    chk("gnt_hold_req", 32'(imem_req), 1);
    chk("gnt_hold_addr", imem_addr, R1);
    do_reset();
    gnt_pct = 100;
    tick(0, 0, 0, 0);
    chk("post_rst_req", 32'(imem_req), 1);
    chk("post_rst_addr", imem_addr, B);
    // randomized stream against the scoreboard
    do_reset();
    gnt_pct = 70;
    lat_lo = 1;
    lat_hi = 3;
    exp_pc = B;
    prev_flush = 1'b0;
    prev_hold = 1'b0;
    delivered = 0;
    sb_on = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(99));
      tick(int'($urandom_range(99) < 65), int'(r < 2), int'(r == 1 || (r >= 2 && r < 5)),
           32'h8000_0000 | (32'($urandom_range(1023)) << 2));
    end
    sb_on = 1'b0;
    chk("progress", 32'(delivered > 500), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_buf.md
# if_fetch_buf

Parametrised instruction-fetch stage with a decoupling instruction queue, sitting between the instruction memory port and ID. It generates sequential fetch PCs, issues block requests of ISSUE_W words, buffers returned instructions with their PCs and fetch-exception flags, and presents up to ISSUE_W instructions per cycle to decode. Exception entry and branch/jump redirects flush the queue and discard the in-flight response, which removes the fixed dual-issue and per-event request-latch scheme of the current IF stage.

## Interface
- ISSUE_W, 2: words per fetch block and max slots delivered per cycle; power of 2, 1..4
- DEPTH, 8: queue entries; power of 2, >= 2*ISSUE_W
- RESET_PC, 32'hbfc0_0000: first fetch address after reset
- EXC_PC, 32'hbfc0_0380: fetch address on exception entry

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  block start PC, held stable while imem_req && !imem_gnt
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in order, >= 1 cycle after gnt)
- imem_rdata  in  32*ISSUE_W  word k = instruction at imem_addr+4k
- exc_valid  in  1  exception/interrupt entry, one-cycle pulse
- redirect_valid  in  1  branch/jump/eret redirect, one-cycle pulse
- redirect_pc  in  32  redirect target
- id_valid  out  ISSUE_W  slot k holds a valid instruction
- id_inst  out  32*ISSUE_W  slot k instruction (0 when adel)
- id_pc  out  32*ISSUE_W  slot k PC
- id_adel  out  ISSUE_W  slot k fetch address error
- id_ready  in  1  ID accepts all valid slots this cycle

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP, HALT.
- IDLE: if fetch_pc[1:0]!=0, push one entry {pc=fetch_pc, inst=0, adel=1} when free >= 1, go HALT. Else if free - 0 >= ISSUE_W, assert imem_req with imem_addr=fetch_pc, go WAIT_GNT (or WAIT_RSP if gnt same cycle).
- WAIT_GNT: imem_req=1, address held; on gnt go WAIT_RSP.
- WAIT_RSP: on rvalid, unless drop set, push ISSUE_W entries {imem_addr+4k, word k, 0}, fetch_pc += 4*ISSUE_W; go IDLE. Space was reserved at request time, so push never overflows.
- HALT: no requests until exc_valid or redirect_valid.
- Flush (exc_valid or redirect_valid): queue emptied; fetch_pc = EXC_PC if exc_valid else redirect_pc (exc wins when both); if state is WAIT_GNT or WAIT_RSP, set drop: request completes normally, its response is discarded, then state IDLE and drop cleared; HALT and IDLE go to IDLE.
- Dequeue: slot k presents entry head+k, id_valid[k] = (count > k). On id_ready, pop min(count, ISSUE_W). Push and pop in the same cycle are both applied.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide; PC adds wrap modulo 2^32.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, id_adel=0, fetch_pc=RESET_PC, count=0, drop=0, state IDLE.
- First imem_req in the first cycle after reset deasserts.
- Response to queue: rvalid at cycle t, so id_valid is set at t+1.
- Flush at t: id_valid=0 at t+1, and imem_req for the new PC at t+1 when no request is outstanding. A pop requested at t is discarded because the flush wins.
- Flush in the same cycle as rvalid: the response is dropped and the new request goes out at t+1.
- Reset mid-request: all state is cleared and the outstanding response is not tracked. The memory side is reset by the same signal.
- Full queue (free < ISSUE_W): no request is issued. Fetch resumes in the cycle after enough entries are popped.

## Structure
- Package if_fetch_pkg contains:
  - fetch_state_e (the 4 states)
  - fetch_entry_t {pc[31:0], inst[31:0], adel}
  - default RESET_PC and EXC_PC constants
- Sub-module if_fetch_fifo is a circular buffer of fetch_entry_t. It has:
  - parametrised push width and pop width
  - count and free outputs
  - a synchronous flush input
- The top level holds the FSM, fetch_pc, the drop flag and the slot output mux.

## Test plan
- Reset and stream (ISSUE_W=2, DEPTH=8, 1-cycle memory, id_ready=1): the first request is at addr bfc0_0000. Slots then carry pc bfc0_0000/bfc0_0004, then bfc0_0008/bfc0_000c, and so on in order.
- Backpressure (id_ready=0): exactly 4 requests are issued and count reaches 8, then imem_req stays 0. Raising id_ready pops 2 per cycle and fetch resumes.
- Redirect during WAIT_RSP to 8000_0100: the late response is dropped, the next request addr is 8000_0100, and no stale PC ever reaches ID.
- exc_valid and redirect_valid together (redirect_pc=8000_0000): the next request addr is bfc0_0380.
- Misaligned redirect to 8000_0102: one slot is delivered with id_adel=1, id_pc=8000_0102, id_inst=0. imem_req stays 0 until exc_valid, after which it fetches bfc0_0380.
- Reset asserted in WAIT_GNT: the next cycle shows all outputs at reset values, then a request at bfc0_0000.
